// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU constants for the fetch stage: FSM encoding, PC step, reset vector
// and the fetch-address legality check.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // An address is illegal if it is not word aligned or lies past the last word.
  function automatic logic fetch_addr_bad(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch stage's control, memory and IF/ID signals.
// inst_valid qualifies inst_out/pc_out for one cycle per delivered word; there is
// no ready: the consumer holds the stage with stall, and a held word stays valid.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic         stall;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_data;
  logic [31:0]  inst_out;
  logic [31:0]  pc_out;
  logic         inst_valid;
  logic         fault;
  logic [31:0]  fetch_count;
  fetch_state_t state;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, inst_out, pc_out, inst_valid, fault, fetch_count, state
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, inst_out, pc_out, inst_valid, fault, fetch_count, state
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the external instruction
// memory, and loads the IF/ID register with stall, branch flush and fault handling.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int          MEM_SIZE = 64,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_data,
  output logic [31:0]  inst_out,
  output logic [31:0]  pc_out,
  output logic         inst_valid,
  output logic         fault,
  output logic [31:0]  fetch_count,
  output fetch_state_t state
);

  localparam logic [31:0] DEPTH = 32'(MEM_SIZE);

  logic [31:0] pc;

  // Memory address comes straight from the register, never from this cycle's inputs.
  assign imem_addr = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst_out    <= 32'd0;
      pc_out      <= 32'd0;
      inst_valid  <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
        end
        RUN: begin
          if (branch_taken) begin
            // Redirect wins over stall; the word fetched this cycle is wrong-path.
            pc         <= branch_target;
            inst_valid <= 1'b0;
          end else if (!stall) begin
            if (fetch_addr_bad(pc, DEPTH)) begin
              state      <= FAULT;
              fault      <= 1'b1;
              inst_valid <= 1'b0;
            end else begin
              inst_out    <= imem_data;
              pc_out      <= pc;
              inst_valid  <= 1'b1;
              pc          <= pc + PC_INC;
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        FAULT: begin
          fault      <= 1'b1;
          inst_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 64, meaning the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, decode-side hold request.
REQ-006 SHALL have port branch_taken, input, 1, redirect request this cycle.
REQ-007 SHALL have port branch_target, input, 32, byte address of the redirect target.
REQ-008 SHALL have port imem_addr, output, 32, byte address driven to the instruction memory, equal to internal pc.
REQ-009 SHALL have port imem_data, input, 32, instruction word returned combinationally by the memory for imem_addr.
REQ-010 SHALL have port inst_out, output, 32, registered instruction (IF/ID register).
REQ-011 SHALL have port pc_out, output, 32, byte address of inst_out.
REQ-012 SHALL have port inst_valid, output, 1, inst_out/pc_out hold a valid instruction.
REQ-013 SHALL have port fault, output, 1, sticky fetch-fault flag.
REQ-014 SHALL have port fetch_count, output, 32, number of instructions delivered with inst_valid=1 since reset.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FAULT; IDLE is entered on reset and always moves to RUN on the next edge with no other state change.
REQ-016 In RUN with the fault check passing, branch_taken=0, stall=0: SHALL load inst_out<=imem_data, pc_out<=pc, inst_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
REQ-017 In RUN with branch_taken=1: SHALL load pc<=branch_target and inst_valid<=0 (flush of wrong-path word), leave fetch_count unchanged, regardless of stall (branch has priority).
REQ-018 In RUN with stall=1 and branch_taken=0: SHALL hold pc, inst_out, pc_out, inst_valid, and fetch_count unchanged.
REQ-019 Fault check: pc[1:0]!=2'b00 or (pc>>2)>=MEM_SIZE; SHALL be evaluated in RUN only when branch_taken=0 and stall=0.
REQ-020 On a failing fault check: SHALL enter FAULT, set fault<=1, inst_valid<=0, leave pc frozen at the faulting address; pc_out and inst_out unchanged.
REQ-021 In FAULT: SHALL ignore stall and branch_taken; fault and inst_valid=0 persist until reset.
REQ-022 A branch_target that is misaligned or out of range SHALL be accepted; the fault is raised on its first unstalled fetch cycle.
REQ-023 pc+4 SHALL wrap modulo 2^32; fetch_count SHALL wrap modulo 2^32.
REQ-024 Latency: an instruction at address A SHALL appear on inst_out one clock edge after imem_addr=A with stall=0 and branch_taken=0.
REQ-025 imem_addr SHALL be driven directly from the pc register (no combinational path from stall/branch inputs).

Reset
REQ-026 While reset=1: pc=RESET_PC, state=IDLE, inst_out=0, pc_out=0, inst_valid=0, fault=0, fetch_count=0, immediately and independent of clock.
REQ-027 Reset asserted mid-operation (any state, including FAULT or during stall) SHALL discard all state; the first valid instruction after deassertion is the word at RESET_PC, two edges later.

Structure
REQ-028 State encoding constants (IDLE, RUN, FAULT) and the PC increment constant 4 SHALL live in the shared CPU package; RESET_PC default SHALL reference the package reset-vector constant.
REQ-029 SHALL be a single module; the instruction memory SHALL be instantiated outside and connected via imem_addr/imem_data.

Verification
REQ-030 Reset release, stall=0, memory words 0..3 = 0x11,0x22,0x33,0x44 -> edge2 inst_out=0x11 pc_out=0; edge5 inst_out=0x44 pc_out=0xC, fetch_count=4.
REQ-031 stall=1 for 3 cycles while inst_out=0x22 -> inst_out, pc_out=4, imem_addr=8, fetch_count held; resumes with 0x33 on first edge after stall drops.
REQ-032 branch_taken=1 target 0x20 with stall=1 simultaneously -> next edge inst_valid=0, imem_addr=0x20; following edge (stall=0) inst_out=word 8, pc_out=0x20.
REQ-033 Branch to 0x102 (misaligned) -> next unstalled edge fault=1, inst_valid=0, imem_addr stays 0x102; later branches ignored.
REQ-034 Sequential run to pc=0xFC with MEM_SIZE=64 -> word 63 delivered, next edge at pc=0x100 sets fault=1.
REQ-035 Assert reset asynchronously in FAULT between edges -> outputs clear immediately; after release, inst_out=word 0 at second edge, fault=0.
